// File: rtl/dot_accum_23.sv
// Per-channel accumulator: sums N_PART partial dot products, adds BIAS, saturates to DATA_LEN.
// Optional macro DOT_ACCUM_RELU_EN clamps negative results to zero instead of saturating them.
module dot_accum_23 #(
  parameter int unsigned DATA_LEN = 16,
  parameter int unsigned N_PART   = 9,
  parameter logic [DATA_LEN-1:0] BIAS = '0,
  parameter int unsigned GUARD    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                in_valid,
  input  logic [DATA_LEN-1:0] in_data,
  output logic                busy,
  output logic                out_valid,
  output logic [DATA_LEN-1:0] out_data,
  output logic                ovf
);

  localparam int unsigned ACC_W = DATA_LEN + GUARD;
  localparam int unsigned CNT_W = 4;
  localparam logic [ACC_W-1:0]    BIAS_EXT = {{GUARD{BIAS[DATA_LEN-1]}}, BIAS};
  localparam logic [DATA_LEN-1:0] SAT_MAX  = {1'b0, {(DATA_LEN-1){1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_BIAS, S_SAT} state_t;

  state_t               state, state_nxt;
  logic                 vld_q;
  logic [ACC_W-1:0]     acc, acc_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 busy_nxt, out_valid_nxt, ovf_nxt;
  logic [DATA_LEN-1:0]  out_data_nxt;
  logic                 sample_c, last_c, pos_sat_c;
  logic [ACC_W-1:0]     data_ext_c;

  // A sample is a rising edge of the level-valid channel
  assign sample_c   = in_valid & ~vld_q;
  assign last_c     = (cnt + CNT_W'(1)) == CNT_W'(N_PART);
  assign data_ext_c = {{GUARD{in_data[DATA_LEN-1]}}, in_data};
  // Guard bits disagreeing with the sign bit mean the value no longer fits DATA_LEN
  assign pos_sat_c  = ~acc[ACC_W-1] & (|acc[ACC_W-2:DATA_LEN-1]);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = S_ACC;
    end else begin
      case (state)
        S_ACC:   if (sample_c && last_c) state_nxt = S_BIAS;
        S_BIAS:  state_nxt = S_SAT;
        S_SAT:   state_nxt = S_IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  // Next values of datapath and registered outputs; start overrides everything
  always_comb begin
    acc_nxt       = acc;
    cnt_nxt       = cnt;
    busy_nxt      = busy;
    out_valid_nxt = 1'b0;
    out_data_nxt  = out_data;
    ovf_nxt       = ovf;
    if (start) begin
      acc_nxt  = '0;
      cnt_nxt  = '0;
      busy_nxt = 1'b1;
      ovf_nxt  = 1'b0;
    end else begin
      case (state)
        S_ACC: begin
          if (sample_c) begin
            acc_nxt = acc + data_ext_c;
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_BIAS: acc_nxt = acc + BIAS_EXT;
        S_SAT: begin
          out_valid_nxt = 1'b1;
          busy_nxt      = 1'b0;
          if (pos_sat_c) begin
            out_data_nxt = SAT_MAX;
            ovf_nxt      = 1'b1;
`ifdef DOT_ACCUM_RELU_EN
          end else if (acc[ACC_W-1]) begin
            out_data_nxt = '0;
`else
          end else if (acc[ACC_W-1] & ~(&acc[ACC_W-2:DATA_LEN-1])) begin
            out_data_nxt = ~SAT_MAX;
            ovf_nxt      = 1'b1;
`endif
          end else begin
            out_data_nxt = acc[DATA_LEN-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      ovf       <= 1'b0;
    end else begin
      vld_q     <= in_valid;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      busy      <= busy_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      ovf       <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_dot_accum_23.sv
// Bench for dot_accum_23: two instances (BIAS 0 and 5) on shared stimulus, checked against
// a transaction-level model every cycle plus hand-computed literals.
module tb_dot_accum_23;

  localparam int unsigned W = 16;
  localparam int unsigned NP = 9;

  logic         clk = 1'b0;
  logic         rst, start, in_valid;
  logic [W-1:0] in_data;
  logic         busy_w[2], ov_w[2], ovf_w[2];
  logic [W-1:0] od_w[2];

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  dot_accum_23 #(.DATA_LEN(W), .N_PART(NP), .BIAS(16'h0000), .GUARD(6)) dut0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .busy(busy_w[0]), .out_valid(ov_w[0]), .out_data(od_w[0]), .ovf(ovf_w[0]));

  dot_accum_23 #(.DATA_LEN(W), .N_PART(NP), .BIAS(16'h0005), .GUARD(6)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .busy(busy_w[1]), .out_valid(ov_w[1]), .out_data(od_w[1]), .ovf(ovf_w[1]));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a transaction is "start, then N_PART rising edges"; result shows up two edges later
  int           bias_m[2] = '{0, 5};
  bit           m_active[2], m_pend_ovf[2];
  int           m_sum[2], m_n[2], m_cd[2];
  logic [W-1:0] m_pend[2], m_last[2];
  logic         e_busy[2], e_valid[2], e_ovf[2];
  logic [W-1:0] e_data[2];
  logic         prev_v;

  function automatic logic [W:0] saturate(input int v);
    if (v > 32767) return {1'b1, 16'h7FFF};
`ifdef DOT_ACCUM_RELU_EN
    if (v < 0) return {1'b0, 16'h0000};
`else
    if (v < -32768) return {1'b1, 16'h8000};
`endif
    return {1'b0, W'(v)};
  endfunction

  always @(posedge clk) begin
    logic [W:0] s;
    for (int k = 0; k < 2; k++) begin
      e_valid[k] = 1'b0;
      if (rst) begin
        m_active[k] = 0; m_cd[k] = 0; m_sum[k] = 0; m_n[k] = 0;
        e_busy[k] = 0; e_data[k] = '0; e_ovf[k] = 0;
      end else begin
        if (m_cd[k] > 0 && !start) begin
          m_cd[k]--;
          if (m_cd[k] == 0) begin
            e_valid[k] = 1'b1;
            e_data[k]  = m_pend[k];
            m_last[k]  = m_pend[k];
            if (m_pend_ovf[k]) e_ovf[k] = 1'b1;
          end
        end
        if (start) begin
          m_active[k] = 1; m_sum[k] = 0; m_n[k] = 0; m_cd[k] = 0; e_ovf[k] = 0;
        end else if (m_active[k] && in_valid && !prev_v) begin
          m_sum[k] += int'($signed(in_data));
          m_n[k]++;
          if (m_n[k] == NP) begin
            m_active[k] = 0;
            s = saturate(m_sum[k] + bias_m[k]);
            m_pend[k] = s[W-1:0];
            m_pend_ovf[k] = s[W];
            m_cd[k] = 2;
          end
        end
        e_busy[k] = m_active[k] || (m_cd[k] > 0);
      end
    end
    prev_v = rst ? 1'b0 : in_valid;
  end

  int           npulse[2] = '{0, 0};
  logic [W-1:0] last_d[2];

  // Single compare process, sampled on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("busy%0d", k), 32'(busy_w[k]), 32'(e_busy[k]));
        chk($sformatf("out_valid%0d", k), 32'(ov_w[k]), 32'(e_valid[k]));
        chk($sformatf("out_data%0d", k), 32'(od_w[k]), 32'(e_data[k]));
        chk($sformatf("ovf%0d", k), 32'(ovf_w[k]), 32'(e_ovf[k]));
        if (ov_w[k] === 1'b1) begin
          npulse[k]++;
          last_d[k] = od_w[k];
        end
      end
    end
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input int hold);
    @(negedge clk); in_valid = 1'b1; in_data = d;
    repeat (hold) @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run(input logic [W-1:0] d, input int hold);
    do_start();
    for (int i = 0; i < NP; i++) send(d, hold);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int lat, p0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
    chk("rst_out_data", 32'(od_w[0]), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Basic sum with latency measurement on the last sample
    do_start();
    for (int i = 0; i < NP - 1; i++) send(16'h0010, 1);
    send(16'h0010, 1);
    lat = 1;
    while (ov_w[0] !== 1'b1 && lat < 10) begin
      @(negedge clk); lat++;
    end
    chk("basic_latency", 32'(lat), 32'd3);
    repeat (3) @(negedge clk);
    chk("basic_pulses", 32'(npulse[0]), 32'd1);
    chk("basic_d0", 32'(last_d[0]), 32'h0090);
    chk("basic_d1", 32'(last_d[1]), 32'h0095);
    chk("basic_model", 32'(m_last[0]), 32'h0090);
    chk("basic_ovf", 32'(ovf_w[0]), 32'd0);

    // Held-high valid counts once per sample
    run(16'h0001, 3);
    chk("held_d0", 32'(last_d[0]), 32'h0009);
    chk("held_d1", 32'(last_d[1]), 32'h000E);
    chk("held_model", 32'(m_last[1]), 32'h000E);
    chk("held_pulses", 32'(npulse[1]), 32'd2);

    // Positive and negative saturation
    run(16'h7000, 1);
    chk("satp_d0", 32'(last_d[0]), 32'h7FFF);
    chk("satp_ovf", 32'(ovf_w[0]), 32'd1);
    run(16'h9000, 1);
`ifdef DOT_ACCUM_RELU_EN
    chk("satn_d0", 32'(last_d[0]), 32'h0000);
    chk("satn_ovf", 32'(ovf_w[0]), 32'd0);
`else
    chk("satn_d0", 32'(last_d[0]), 32'h8000);
    chk("satn_ovf", 32'(ovf_w[0]), 32'd1);
`endif

    // Abort with start coincident with an in_valid edge
    p0 = npulse[0];
    do_start();
    for (int i = 0; i < 4; i++) send(16'h0003, 1);
    @(negedge clk); start = 1'b1; in_valid = 1'b1; in_data = 16'h0050;
    @(negedge clk); start = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < NP; i++) send(16'h0002, 1);
    repeat (4) @(negedge clk);
    chk("abort_pulses", 32'(npulse[0] - p0), 32'd1);
    chk("abort_d0", 32'(last_d[0]), 32'h0012);
    chk("abort_d1", 32'(last_d[1]), 32'h0017);

    // Reset mid-accumulation, then edges in IDLE are ignored
    p0 = npulse[0];
    do_start();
    for (int i = 0; i < 5; i++) send(16'h0004, 1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("midrst_busy", 32'(busy_w[0]), 32'd0);
    chk("midrst_out_data", 32'(od_w[0]), 32'd0);
    for (int i = 0; i < NP; i++) send(16'h0004, 1);
    repeat (4) @(negedge clk);
    chk("idle_busy", 32'(busy_w[0]), 32'd0);
    chk("idle_pulses", 32'(npulse[0] - p0), 32'd0);
    run(16'h0004, 1);
    chk("fresh_d0", 32'(last_d[0]), 32'h0024);

    // Back-to-back: start in the out_valid cycle
    p0 = npulse[0];
    do_start();
    for (int i = 0; i < NP; i++) send(16'h0002, 1);
    lat = 0;
    while (ov_w[0] !== 1'b1 && lat < 10) begin
      @(negedge clk); lat++;
    end
    chk("b2b_seen", 32'(ov_w[0]), 32'd1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < NP; i++) send(16'h0001, 1);
    repeat (4) @(negedge clk);
    chk("b2b_pulses", 32'(npulse[0] - p0), 32'd2);
    chk("b2b_d0", 32'(last_d[0]), 32'h0009);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
